// File: rtl/pirdsp_pkg.sv
// Shared PIRDSP definitions: carry-out field layout of the P register stage.
package pirdsp_pkg;

  localparam int unsigned CARRY_W  = 5;
  localparam int unsigned SIDM_BIT = 4;
  localparam int unsigned CZ_LSB   = 2;
  localparam int unsigned CW_LSB   = 0;

  typedef struct packed {
    logic       sidm;
    logic [1:0] cz;
    logic [1:0] cw;
  } carry_t;

endpackage

// File: rtl/alu_p_register_stage_pattern_detector.sv
// Masked pattern / inverted-pattern match on the ALU result (combinational).
module pattern_detector #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] s_in,
  input  logic [Width-1:0] pattern,
  input  logic [Width-1:0] mask,
  output logic             pd,
  output logic             pdb
);

  assign pd  = &((s_in ~^ pattern) | mask);
  assign pdb = &((s_in ^ pattern) | mask);

endmodule

// File: rtl/alu_p_register_stage.sv
// P register and accumulation-window control downstream of the SIMD ALU,
// with registered pattern-detect and overflow/underflow flags.
module alu_p_register_stage
  import pirdsp_pkg::*;
#(
  parameter int unsigned Width    = 8,
  parameter int unsigned LenWidth = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ce_p,
  input  logic                in_valid,
  input  logic [Width-1:0]    s_in,
  input  logic [1:0]          cout_w_x_y_in,
  input  logic [1:0]          cout_z_w_x_y_in,
  input  logic                sidm_carry_in,
  input  logic [LenWidth-1:0] acc_len,
  input  logic                acc_clear,
  input  logic [Width-1:0]    pattern,
  input  logic [Width-1:0]    mask,
  output logic [Width-1:0]    p,
  output logic [CARRY_W-1:0]  carry_out,
  output logic                fb_zero,
  output logic                p_done,
  output logic                pattern_detect,
  output logic                pattern_b_detect,
  output logic                overflow,
  output logic                underflow,
  output logic                ovf_sticky
);

  logic [Width-1:0]    p_q, p_d;
  carry_t              carry_q, carry_d;
  logic [LenWidth-1:0] cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                pd_q, pd_d, pdb_q, pdb_d;
  logic                ovf_q, ovf_d, unf_q, unf_d;
  logic                sticky_q, sticky_d;

  logic                pd, pdb;
  logic                accept;
  logic                first;
  logic                ou;
  logic [LenWidth-1:0] pos;

  pattern_detector #(.Width(Width)) u_pattern_detector (
    .s_in    (s_in),
    .pattern (pattern),
    .mask    (mask),
    .pd      (pd),
    .pdb     (pdb)
  );

  assign accept = ce_p & in_valid;

  // Next-state: accepts advance the window; a clear alone restarts it.
  always_comb begin
    p_d      = p_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    pd_d     = pd_q;
    pdb_d    = pdb_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    sticky_d = sticky_q;
    first    = 1'b0;
    ou       = 1'b0;
    pos      = cnt_q;

    if (accept) begin
      p_d     = s_in;
      carry_d = '{sidm: sidm_carry_in, cz: cout_z_w_x_y_in, cw: cout_w_x_y_in};
      pd_d    = pd;
      pdb_d   = pdb;
      ovf_d   = pd_q & ~pd & ~pdb;
      unf_d   = pdb_q & ~pd & ~pdb;
      ou      = ovf_d | unf_d;
      first   = acc_clear | (cnt_q == '0);
      pos     = acc_clear ? '0 : cnt_q;
      // >= rather than == so a shortened acc_len closes an overrun window.
      if (pos >= acc_len) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d  = pos + LenWidth'(1);
        done_d = 1'b0;
      end
      sticky_d = first ? ou : (sticky_q | ou);
    end else begin
      if (ce_p) begin
        done_d = 1'b0;
      end
      if (acc_clear) begin
        cnt_d    = '0;
        sticky_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q      <= '0;
      carry_q  <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      pd_q     <= 1'b0;
      pdb_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      p_q      <= p_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      pd_q     <= pd_d;
      pdb_q    <= pdb_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      sticky_q <= sticky_d;
    end
  end

  assign p                = p_q;
  assign carry_out        = carry_q;
  assign fb_zero          = (cnt_q == '0);
  assign p_done           = done_q;
  assign pattern_detect   = pd_q;
  assign pattern_b_detect = pdb_q;
  assign overflow         = ovf_q;
  assign underflow        = unf_q;
  assign ovf_sticky       = sticky_q;

endmodule
